demux1to4_reg: RTL and testbench

DEMUX1TO4_REG -- requirements
Module: demux1to4_reg

---
 rtl/demux1to4_reg.sv | 70 +++++++
 tb/tb_demux1to4_reg.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/demux1to4_reg.sv
// One-entry registered 1-to-4 demultiplexer: holds a word plus its destination
// and presents it on a shared data bus qualified by a one-hot valid.
module demux1to4_reg #(
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic                  arstn,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [1:0]            i_dest,
    input  logic [DATA_WIDTH-1:0] i_data,
    output logic [3:0]            o_valid,
    input  logic [3:0]            i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [15:0]           o_xfer_count
);

    typedef enum logic {EMPTY, FULL} state_t;

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] data_q;
    logic [1:0]            dest_q;
    logic [15:0]           cnt_q;
    logic                  sel_rdy, up_xfer, dn_xfer;

    // Only the ready of the held word's destination matters.
    assign sel_rdy = i_ready[dest_q];

    always_comb begin
        state_d = state_q;
        o_ready = 1'b1;
        o_valid = 4'b0000;
        dn_xfer = 1'b0;
        up_xfer = 1'b0;
        case (state_q)
            EMPTY: begin
                up_xfer = i_valid;
                if (i_valid) state_d = FULL;
            end
            FULL: begin
                o_ready         = sel_rdy;
                o_valid[dest_q] = 1'b1;
                dn_xfer         = sel_rdy;
                up_xfer         = i_valid && sel_rdy;
                if (sel_rdy && !i_valid) state_d = EMPTY;
            end
            default: state_d = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            state_q <= EMPTY;
            data_q  <= '0;
            dest_q  <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            if (up_xfer) begin
                data_q <= i_data;
                dest_q <= i_dest;
            end
            if (dn_xfer) cnt_q <= cnt_q + 16'd1;
        end
    end

    assign o_data       = data_q;
    assign o_xfer_count = cnt_q;

endmodule

// File: tb/tb_demux1to4_reg.sv
// Directed testbench for demux1to4_reg: routing, backpressure, streaming,
// async reset and transfer-counter wrap.
module tb_demux1to4_reg;

    localparam int DW = 64;

    logic          clk = 1'b0;
    logic          arstn = 1'b1;
    logic          i_valid = 1'b0;
    logic          o_ready;
    logic [1:0]    i_dest = '0;
    logic [DW-1:0] i_data = '0;
    logic [3:0]    o_valid;
    logic [3:0]    i_ready = '0;
    logic [DW-1:0] o_data;
    logic [15:0]   o_xfer_count;

    int checks = 0;
    int errors = 0;

    demux1to4_reg #(.DATA_WIDTH(DW)) dut (
        .clk(clk), .arstn(arstn), .i_valid(i_valid), .o_ready(o_ready),
        .i_dest(i_dest), .i_data(i_data), .o_valid(o_valid),
        .i_ready(i_ready), .o_data(o_data), .o_xfer_count(o_xfer_count)
    );

    always #5 clk = ~clk;

    // Inputs change 1 time unit after the rising edge; checks sit 4 units later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic apply_reset();
        i_valid = 1'b0;
        i_ready = 4'b0000;
        arstn   = 1'b0;
        tick();
        arstn   = 1'b1;
    endtask

    task automatic test_reset();
        i_valid = 1'b1;
        i_dest  = 2'd3;
        i_data  = 64'hDEAD;
        i_ready = 4'b1111;
        #1 arstn = 1'b0;
        #1;
        checks++;
        if (o_valid !== 4'b0000) begin errors++; $display("FAIL reset_valid got=%b exp=%b", o_valid, 4'b0000); end
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
        checks++;
        if (o_data !== 64'h0) begin errors++; $display("FAIL reset_data got=%h exp=0", o_data); end
        checks++;
        if (o_xfer_count !== 16'h0) begin errors++; $display("FAIL reset_count got=%h exp=0", o_xfer_count); end
        tick();
        tick();
        checks++;
        if (o_valid !== 4'b0000) begin errors++; $display("FAIL reset_held_valid got=%b exp=0000", o_valid); end
        i_valid = 1'b0;
        arstn   = 1'b1;
    endtask

    task automatic test_single();
        i_valid = 1'b1;
        i_dest  = 2'd2;
        i_data  = 64'hA5A5;
        i_ready = 4'b1111;
        settle();
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL single_ready got=%b exp=1", o_ready); end
        tick();
        i_valid = 1'b0;
        settle();
        checks++;
        if (o_valid !== 4'b0100) begin errors++; $display("FAIL single_valid got=%b exp=0100", o_valid); end
        checks++;
        if (o_data !== 64'hA5A5) begin errors++; $display("FAIL single_data got=%h exp=a5a5", o_data); end
        tick();
        settle();
        checks++;
        if (o_valid !== 4'b0000) begin errors++; $display("FAIL single_drain got=%b exp=0000", o_valid); end
        checks++;
        if (o_xfer_count !== 16'd1) begin errors++; $display("FAIL single_count got=%0d exp=1", o_xfer_count); end
    endtask

    task automatic test_backpressure();
        i_valid = 1'b1;
        i_dest  = 2'd1;
        i_data  = 64'h1111;
        i_ready = 4'b1101;
        tick();
        // A competing word stays on the bus and must not be accepted.
        i_dest = 2'd3;
        i_data = 64'h2222;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (o_valid !== 4'b0010) begin errors++; $display("FAIL bp_valid cyc=%0d got=%b exp=0010", c, o_valid); end
            checks++;
            if (o_data !== 64'h1111) begin errors++; $display("FAIL bp_data cyc=%0d got=%h exp=1111", c, o_data); end
            checks++;
            if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready cyc=%0d got=%b exp=0", c, o_ready); end
            tick();
        end
        i_ready = 4'b1111;
        settle();
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got=%b exp=1", o_ready); end
        tick();
        i_valid = 1'b0;
        settle();
        checks++;
        if (o_valid !== 4'b1000 || o_data !== 64'h2222) begin
            errors++; $display("FAIL bp_second got=%b/%h exp=1000/2222", o_valid, o_data);
        end
        tick();
        settle();
        checks++;
        if (o_xfer_count !== 16'd3) begin errors++; $display("FAIL bp_count got=%0d exp=3", o_xfer_count); end
    endtask

    task automatic test_streaming();
        logic [3:0] exp_v;
        apply_reset();
        i_ready = 4'b1111;
        for (int i = 0; i < 9; i++) begin
            i_valid = (i < 8);
            i_dest  = 2'(i % 4);
            i_data  = 64'h100 + 64'(i);
            settle();
            checks++;
            if (o_ready !== 1'b1) begin errors++; $display("FAIL stream_ready i=%0d got=%b exp=1", i, o_ready); end
            if (i > 0) begin
                exp_v = 4'b0001 << ((i - 1) % 4);
                checks++;
                if (o_valid !== exp_v || o_data !== 64'h100 + 64'(i - 1)) begin
                    errors++;
                    $display("FAIL stream_word i=%0d got=%b/%h exp=%b/%h", i, o_valid, o_data, exp_v, 64'h100 + 64'(i - 1));
                end
            end
            tick();
        end
        settle();
        checks++;
        if (o_xfer_count !== 16'd8) begin errors++; $display("FAIL stream_count got=%0d exp=8", o_xfer_count); end
    endtask

    task automatic test_irrelevant_ready();
        apply_reset();
        i_valid = 1'b1;
        i_dest  = 2'd3;
        i_data  = 64'h3333;
        tick();
        i_valid = 1'b0;
        i_ready = 4'b0111;
        for (int c = 0; c < 3; c++) begin
            settle();
            checks++;
            if (o_valid !== 4'b1000 || o_ready !== 1'b0 || o_xfer_count !== 16'd0) begin
                errors++;
                $display("FAIL irr_hold cyc=%0d got=%b/%b/%0d exp=1000/0/0", c, o_valid, o_ready, o_xfer_count);
            end
            tick();
        end
        i_ready = 4'b1000;
        settle();
        checks++;
        if (o_ready !== 1'b1) begin errors++; $display("FAIL irr_ready got=%b exp=1", o_ready); end
        tick();
        settle();
        checks++;
        if (o_valid !== 4'b0000 || o_xfer_count !== 16'd1) begin
            errors++; $display("FAIL irr_done got=%b/%0d exp=0000/1", o_valid, o_xfer_count);
        end
    endtask

    task automatic test_reset_mid();
        i_valid = 1'b1;
        i_dest  = 2'd0;
        i_data  = 64'h4444;
        i_ready = 4'b0000;
        tick();
        i_valid = 1'b0;
        settle();
        checks++;
        if (o_valid !== 4'b0001) begin errors++; $display("FAIL mid_full got=%b exp=0001", o_valid); end
        #1 arstn = 1'b0;
        #1;
        checks++;
        if (o_valid !== 4'b0000 || o_xfer_count !== 16'd0 || o_data !== 64'h0 || o_ready !== 1'b1) begin
            errors++;
            $display("FAIL mid_async got=%b/%0d/%h/%b exp=0000/0/0/1", o_valid, o_xfer_count, o_data, o_ready);
        end
        tick();
        arstn   = 1'b1;
        i_ready = 4'b1111;
        settle();
        checks++;
        if (o_valid !== 4'b0000) begin errors++; $display("FAIL mid_discard got=%b exp=0000", o_valid); end
        i_valid = 1'b1;
        i_dest  = 2'd2;
        i_data  = 64'h5555;
        tick();
        i_valid = 1'b0;
        settle();
        checks++;
        if (o_valid !== 4'b0100 || o_data !== 64'h5555) begin
            errors++; $display("FAIL mid_new got=%b/%h exp=0100/5555", o_valid, o_data);
        end
        tick();
        settle();
        checks++;
        if (o_xfer_count !== 16'd1) begin errors++; $display("FAIL mid_count got=%0d exp=1", o_xfer_count); end
    endtask

    task automatic test_counter_wrap();
        apply_reset();
        i_valid = 1'b1;
        i_dest  = 2'd0;
        i_data  = 64'h77;
        i_ready = 4'b1111;
        // First edge only loads; each later edge completes one transfer.
        for (int c = 0; c < 65536; c++) tick();
        settle();
        checks++;
        if (o_xfer_count !== 16'hFFFF) begin errors++; $display("FAIL wrap_max got=%h exp=ffff", o_xfer_count); end
        tick();
        i_valid = 1'b0;
        settle();
        checks++;
        if (o_xfer_count !== 16'h0000) begin errors++; $display("FAIL wrap_zero got=%h exp=0000", o_xfer_count); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_backpressure();
        test_streaming();
        test_irrelevant_ready();
        test_reset_mid();
        test_counter_wrap();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
